// File: rtl/pes_elc_pkg.sv
// Shared elevator-controller definitions: dispatcher state encoding and floor
// one-hot/index conversion helpers used by both dispatcher and controller.
package pes_elc_pkg;

    localparam int FLOORS_DEFAULT = 8;
    // Helpers work at a fixed maximum width; callers cast to their own width.
    localparam int MAX_FLOORS = 64;
    localparam int MAX_IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        HOLD   = 2'd3
    } elc_state_t;

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (oh[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [MAX_FLOORS-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_FLOORS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pes_elc_scan_select.sv
// SCAN target picker: from the pending calls, cabin index and sweep direction,
// returns the next target floor (one-hot), whether one exists, and whether the sweep reverses.
module pes_elc_scan_select
    import pes_elc_pkg::*;
#(
    parameter int NUM_FLOORS = FLOORS_DEFAULT,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic                  sweep_up,
    output logic [NUM_FLOORS-1:0] target,
    output logic                  found,
    output logic                  flip
);

    logic             up_hit, below_hit, dn_hit, above_hit;
    logic [IDX_W-1:0] up_idx, below_idx, dn_idx, above_idx, tgt_idx;

    // Descending scan keeps the lowest match, ascending scan keeps the highest.
    always_comb begin
        up_hit    = 1'b0;
        above_hit = 1'b0;
        dn_hit    = 1'b0;
        below_hit = 1'b0;
        up_idx    = '0;
        above_idx = '0;
        dn_idx    = '0;
        below_idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i >= int'(cur_idx)) begin
                up_hit = 1'b1;
                up_idx = IDX_W'(i);
            end
            if (pending[i] && i > int'(cur_idx)) begin
                above_hit = 1'b1;
                above_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && i <= int'(cur_idx)) begin
                dn_hit = 1'b1;
                dn_idx = IDX_W'(i);
            end
            if (pending[i] && i < int'(cur_idx)) begin
                below_hit = 1'b1;
                below_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        flip    = 1'b0;
        tgt_idx = '0;
        if (sweep_up) begin
            if (up_hit) begin
                found   = 1'b1;
                tgt_idx = up_idx;
            end else if (below_hit) begin
                found   = 1'b1;
                flip    = 1'b1;
                tgt_idx = below_idx;
            end
        end else begin
            if (dn_hit) begin
                found   = 1'b1;
                tgt_idx = dn_idx;
            end else if (above_hit) begin
                found   = 1'b1;
                flip    = 1'b1;
                tgt_idx = above_idx;
            end
        end
        target = found ? NUM_FLOORS'(idx_to_onehot(MAX_IDX_W'(tgt_idx))) : '0;
    end

endmodule

// File: rtl/pes_elc_call_dispatcher.sv
// Elevator call dispatcher: latches call buttons, picks targets with a SCAN sweep,
// presents one request at a time to the controller and dwells after each completion.
module pes_elc_call_dispatcher
    import pes_elc_pkg::*;
#(
    parameter int NUM_FLOORS = FLOORS_DEFAULT,
    parameter int DOOR_HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [NUM_FLOORS-1:0] current_floor,
    input  logic                  complete,
    input  logic                  door_alert,
    input  logic                  weight_alert,
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic                  request_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_up,
    output logic                  busy
);

    localparam int               IDX_W     = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int               CNT_W     = $clog2(DOOR_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DOOR_HOLD - 1);

    elc_state_t            state, state_nxt;
    logic [NUM_FLOORS-1:0] pending_q, req_q, clr, target;
    logic                  sweep_q, found, flip, load_target;
    logic [CNT_W-1:0]      dwell_q;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_valid, alert, dwell_done;

    assign cur_idx    = IDX_W'(onehot_to_idx(MAX_FLOORS'(current_floor)));
    assign cur_valid  = $onehot(current_floor);
    assign alert      = door_alert | weight_alert;
    assign dwell_done = (dwell_q == HOLD_LAST);

    pes_elc_scan_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .IDX_W      (IDX_W)
    ) u_scan_select (
        .pending  (pending_q),
        .cur_idx  (cur_idx),
        .sweep_up (sweep_q),
        .target   (target),
        .found    (found),
        .flip     (flip)
    );

    always_comb begin
        state_nxt   = state;
        load_target = 1'b0;
        clr         = '0;
        case (state)
            IDLE: begin
                if ((|pending_q) && cur_valid && !alert) state_nxt = SELECT;
            end
            SELECT: begin
                if ((|pending_q) && cur_valid && found) begin
                    state_nxt   = ISSUE;
                    load_target = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            // Alerts are deliberately not sampled here: an issued request runs to completion.
            ISSUE: begin
                if (complete) begin
                    state_nxt = HOLD;
                    clr       = req_q;
                end
            end
            HOLD: begin
                if (dwell_done && !alert) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pending_q <= '0;
            req_q     <= '0;
            sweep_q   <= 1'b1;
            dwell_q   <= '0;
        end else begin
            state     <= state_nxt;
            pending_q <= (pending_q | call_btn) & ~clr;
            if (load_target) begin
                req_q   <= target;
                sweep_q <= sweep_q ^ flip;
            end
            if (state == ISSUE) begin
                dwell_q <= '0;
            end else if (state == HOLD && !dwell_done) begin
                dwell_q <= dwell_q + 1'b1;
            end
        end
    end

    assign request_floor = req_q;
    assign request_valid = (state == ISSUE);
    assign pending       = pending_q;
    assign sweep_up      = sweep_q;
    assign busy          = (state != IDLE);

endmodule
